nvdla_attn_out_writer: RTL and testbench

NVDLA_ATTN_OUT_WRITER -- requirements
Module: nvdla_attn_out_writer

---
 rtl/nvdla_attn_out_writer.sv | 145 ++++++++++++++
 tb/tb_nvdla_attn_out_writer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_attn_out_writer.sv
// Gathers 8-element attention output beats into 32-element bursts.
// Out-of-window or duplicate-slot beats park in a one-entry pending register.
module nvdla_attn_out_writer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [127:0]      in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [511:0]      mem_data,
    output logic [3:0]        mem_mask,
    input  logic              mem_ack,
    output logic              flush_done,
    output logic              wr_error,
    output logic [31:0]       beats_written
);

    typedef enum logic {FILL, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [3:0][127:0]  buf_q;
    logic [3:0]         mask_q;
    logic               pend_valid_q;
    logic [ADDR_W-1:3]  pend_addr_q;
    logic [127:0]       pend_data_q;
    logic               flush_pend_q;
    logic               flush_act_q;
    logic               flush_done_q;
    logic               wr_error_q;
    logic [31:0]        beats_q;

    logic               acc, misal, good, conflict, flush_eff, issue_go;
    logic [ADDR_W-1:0]  win;
    logic [1:0]         slot;
    logic [3:0]         slot_bit, new_mask, pend_bit;
    logic [31:0]        pop;

    assign in_ready = (state_q == FILL) && !rst;
    assign acc      = in_valid && in_ready;
    assign misal    = acc && (in_addr[2:0] != 3'b000);
    assign good     = acc && !misal;
    assign win      = {in_addr[ADDR_W-1:5], 5'b0};
    assign slot     = in_addr[4:3];
    assign slot_bit = 4'b0001 << slot;
    assign pend_bit = 4'b0001 << pend_addr_q[4:3];
    assign pop      = 32'(mask_q[0]) + 32'(mask_q[1])
                    + 32'(mask_q[2]) + 32'(mask_q[3]);

    // A latched flush from ISSUE takes effect on the first FILL cycle.
    assign flush_eff = flush || flush_pend_q;
    assign conflict  = good && (mask_q != 4'b0) &&
                       ((win != base_q) || ((mask_q & slot_bit) != 4'b0));
    assign new_mask  = (good && !conflict) ? (mask_q | slot_bit) : mask_q;
    assign issue_go  = conflict || (new_mask == 4'hF) ||
                       (flush_eff && (new_mask != 4'b0));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (issue_go) state_d = ISSUE;
            ISSUE:   if (mem_ack)  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        mem_data = '0;
        for (int s = 0; s < 4; s++)
            if (state_q == ISSUE && mask_q[s])
                mem_data[128*s +: 128] = buf_q[s];
    end

    assign mem_req       = (state_q == ISSUE);
    assign mem_addr      = mem_req ? base_q : '0;
    assign mem_mask      = mem_req ? mask_q : 4'b0;
    assign flush_done    = flush_done_q;
    assign wr_error      = wr_error_q;
    assign beats_written = beats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            base_q       <= '0;
            buf_q        <= '0;
            mask_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            flush_pend_q <= 1'b0;
            flush_act_q  <= 1'b0;
            flush_done_q <= 1'b0;
            wr_error_q   <= 1'b0;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= 1'b0;
            if (misal) wr_error_q <= 1'b1;
            unique case (state_q)
                FILL: begin
                    flush_pend_q <= 1'b0;
                    if (conflict) begin
                        pend_valid_q <= 1'b1;
                        pend_addr_q  <= in_addr[ADDR_W-1:3];
                        pend_data_q  <= in_data;
                        flush_pend_q <= flush_eff;
                    end else if (good) begin
                        if (mask_q == 4'b0) base_q <= win;
                        buf_q[slot] <= in_data;
                        mask_q      <= new_mask;
                    end
                    if (flush_eff && !conflict) begin
                        if (new_mask != 4'b0) flush_act_q  <= 1'b1;
                        else                  flush_done_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (mem_ack) begin
                        beats_q <= beats_q + pop;
                        buf_q   <= '0;
                        mask_q  <= 4'b0;
                        if (pend_valid_q) begin
                            base_q  <= {pend_addr_q[ADDR_W-1:5], 5'b0};
                            buf_q[pend_addr_q[4:3]] <= pend_data_q;
                            mask_q  <= pend_bit;
                            pend_valid_q <= 1'b0;
                        end
                        if (flush_act_q) begin
                            flush_act_q  <= 1'b0;
                            flush_done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_attn_out_writer.sv
// Directed bench for nvdla_attn_out_writer burst gathering and flush.
module tb_nvdla_attn_out_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_addr = '0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [511:0] mem_data;
    logic [3:0]   mem_mask;
    logic         mem_ack = 1'b0;
    logic         flush_done;
    logic         wr_error;
    logic [31:0]  beats_written;

    int checks = 0;
    int failures = 0;

    nvdla_attn_out_writer #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_mask(mem_mask), .mem_ack(mem_ack),
        .flush_done(flush_done), .wr_error(wr_error),
        .beats_written(beats_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] bd(input logic [31:0] k);
        return {k, ~k, k + 32'd1, k + 32'd2};
    endfunction

    task automatic beat(input logic [31:0] a, input logic [127:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        check("beat_rdy", 512'(in_ready), 512'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    logic [511:0] exp_d;

    initial begin
        // reset state
        tick();
        tick();
        check("rst_req", 512'(mem_req), 512'd0);
        check("rst_rdy", 512'(in_ready), 512'd0);
        check("rst_cnt", 512'(beats_written), 512'd0);
        check("rst_err", 512'(wr_error), 512'd0);
        check("rst_fd", 512'(flush_done), 512'd0);
        check("rst_mask", 512'(mem_mask), 512'd0);
        check("rst_data", mem_data, 512'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 512'(in_ready), 512'd1);

        // four contiguous beats, ack held high
        mem_ack = 1'b1;
        beat(32'h40, bd(32'h100));
        beat(32'h48, bd(32'h200));
        beat(32'h50, bd(32'h300));
        beat(32'h58, bd(32'h400));
        check("t1_req", 512'(mem_req), 512'd1);
        check("t1_addr", 512'(mem_addr), 512'h40);
        check("t1_mask", 512'(mem_mask), 512'hF);
        check("t1_data", mem_data,
              {bd(32'h400), bd(32'h300), bd(32'h200), bd(32'h100)});
        check("t1_rdy", 512'(in_ready), 512'd0);
        tick();
        check("t1_req_lo", 512'(mem_req), 512'd0);
        check("t1_cnt", 512'(beats_written), 512'd4);
        check("t1_rdy_hi", 512'(in_ready), 512'd1);
        mem_ack = 1'b0;

        // partial burst drained by flush
        beat(32'h00, bd(32'h500));
        beat(32'h08, bd(32'h600));
        pulse_flush();
        check("t2_req", 512'(mem_req), 512'd1);
        check("t2_addr", 512'(mem_addr), 512'h0);
        check("t2_mask", 512'(mem_mask), 512'h3);
        check("t2_data", mem_data,
              {256'd0, bd(32'h600), bd(32'h500)});
        check("t2_fd_early", 512'(flush_done), 512'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t2_req_lo", 512'(mem_req), 512'd0);
        check("t2_fd", 512'(flush_done), 512'd1);
        check("t2_cnt", 512'(beats_written), 512'd6);
        tick();
        check("t2_fd_lo", 512'(flush_done), 512'd0);

        // window change parks a beat; ack withheld; flush latched
        beat(32'h00, bd(32'h700));
        beat(32'h08, bd(32'h800));
        beat(32'h40, bd(32'h900));
        exp_d = {256'd0, bd(32'h800), bd(32'h700)};
        check("t3_req", 512'(mem_req), 512'd1);
        check("t3_addr", 512'(mem_addr), 512'h0);
        check("t3_mask", 512'(mem_mask), 512'h3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) flush = 1'b1;
            tick();
            flush = 1'b0;
            check("t3_hold_req", 512'(mem_req), 512'd1);
            check("t3_hold_addr", 512'(mem_addr), 512'h0);
            check("t3_hold_mask", 512'(mem_mask), 512'h3);
            check("t3_hold_data", mem_data, exp_d);
            check("t3_hold_rdy", 512'(in_ready), 512'd0);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t3_req_lo", 512'(mem_req), 512'd0);
        check("t3_cnt", 512'(beats_written), 512'd8);
        check("t3_rdy", 512'(in_ready), 512'd1);
        check("t3_fd_no", 512'(flush_done), 512'd0);
        tick();
        check("t3p_req", 512'(mem_req), 512'd1);
        check("t3p_addr", 512'(mem_addr), 512'h40);
        check("t3p_mask", 512'(mem_mask), 512'h1);
        check("t3p_data", mem_data, {384'd0, bd(32'h900)});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t3p_fd", 512'(flush_done), 512'd1);
        check("t3p_cnt", 512'(beats_written), 512'd9);

        // flush with nothing buffered
        pulse_flush();
        check("t4_fd", 512'(flush_done), 512'd1);
        check("t4_req", 512'(mem_req), 512'd0);
        tick();
        check("t4_fd_lo", 512'(flush_done), 512'd0);

        // misaligned beat is dropped and flagged
        beat(32'h03, bd(32'hA00));
        check("t5_err", 512'(wr_error), 512'd1);
        check("t5_req", 512'(mem_req), 512'd0);
        check("t5_cnt", 512'(beats_written), 512'd9);
        flush = 1'b1;
        beat(32'h00, bd(32'hB00));
        flush = 1'b0;
        check("t5_mask", 512'(mem_mask), 512'h1);
        check("t5_data", mem_data, {384'd0, bd(32'hB00)});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t5_fd", 512'(flush_done), 512'd1);
        check("t5_cnt2", 512'(beats_written), 512'd10);
        check("t5_err_sticky", 512'(wr_error), 512'd1);

        // reset in the middle of ISSUE
        beat(32'h00, bd(32'hC00));
        beat(32'h08, bd(32'hD00));
        beat(32'h10, bd(32'hE00));
        pulse_flush();
        check("t6_mask", 512'(mem_mask), 512'h7);
        check("t6_req", 512'(mem_req), 512'd1);
        rst = 1'b1;
        tick();
        check("t6_req_lo", 512'(mem_req), 512'd0);
        check("t6_cnt", 512'(beats_written), 512'd0);
        check("t6_err", 512'(wr_error), 512'd0);
        check("t6_rdy_lo", 512'(in_ready), 512'd0);
        check("t6_addr", 512'(mem_addr), 512'd0);
        rst = 1'b0;
        #1;
        check("t6_rdy", 512'(in_ready), 512'd1);
        tick();
        check("t6_req_idle", 512'(mem_req), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
